// File: rtl/ysyx_23060061_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   RESET_PC_DEF : default architectural PC after reset
//   RESP_OKAY    : AXI4-Lite OKAY response code
//   S_*          : 2-bit fetch FSM state encoding
package ysyx_23060061_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_RESP  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

endpackage

// File: rtl/ysyx_23060061_ifu_if.sv
// AXI4-Lite read channel (AR/R only) between the fetch unit and the
// instruction memory / arbiter.
//   master : fetch unit (drives araddr, arvalid, rready)
//   slave  : memory side (drives arready, rdata, rresp, rvalid)
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high; a source holds valid and its payload stable until that edge.
interface ysyx_23060061_ifu_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit. Holds the architectural PC, fetches one 32-bit
// instruction per step over the AXI4-Lite read channel and hands it to the
// execute stage, then waits for that stage's next PC.
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   axi        AR/R read channel (master side)
//   inst       instruction to execute stage, held while instValid
//   instValid  inst valid; held until exec_done
//   pc         PC of inst (also the fetch address)
//   exec_done  execute stage finished inst; dnpc valid this cycle
//   dnpc       next PC from execute stage
//   fetch_err  sticky fault: bad read response or misaligned dnpc
//   stateDbg   current FSM state
module ysyx_23060061_ifu
    import ysyx_23060061_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060061_ifu_if.master        axi,
    output logic [31:0]                inst,
    output logic                       instValid,
    output logic [31:0]                pc,
    input  logic                       exec_done,
    input  logic [31:0]                dnpc,
    output logic                       fetch_err,
    output logic [1:0]                 stateDbg
);

    logic [1:0] state;
    logic       arvalidQ;
    logic       rreadyQ;

    assign axi.araddr  = pc;
    assign axi.arvalid = arvalidQ;
    assign axi.rready  = rreadyQ;
    assign stateDbg    = state;

    // Handshake outputs are registered and set on entry to their state, so
    // they drop with the asynchronous reset and never overlap each other.
    // Reset leaves state=S_REQ with arvalid low; the first edge out of reset
    // raises arvalid, and a handshake is only recognised once it is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            inst      <= 32'h0;
            instValid <= 1'b0;
            fetch_err <= 1'b0;
            arvalidQ  <= 1'b0;
            rreadyQ   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (arvalidQ && axi.arready) begin
                        arvalidQ <= 1'b0;
                        rreadyQ  <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        arvalidQ <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (axi.rvalid) begin
                        rreadyQ <= 1'b0;
                        if (axi.rresp == RESP_OKAY) begin
                            inst      <= axi.rdata;
                            instValid <= 1'b1;
                            state     <= S_VALID;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                S_VALID: begin
                    if (exec_done) begin
                        instValid <= 1'b0;
                        if (dnpc[1:0] == 2'b00) begin
                            pc       <= dnpc;
                            arvalidQ <= 1'b1;
                            state    <= S_REQ;
                        end else begin
                            // Misaligned target: keep the faulting
                            // instruction's PC for inspection.
                            fetch_err <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                default: begin
                    // S_ERR: bus idle until reset.
                    arvalidQ  <= 1'b0;
                    rreadyQ   <= 1'b0;
                    instValid <= 1'b0;
                    fetch_err <= 1'b1;
                    state     <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Testbench for ysyx_23060061_ifu: directed fetch sequences with a
// scoreboard of expected fetch addresses and delivered instructions.
module tb_ysyx_23060061_ifu;
    import ysyx_23060061_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060061_ifu_if bus();

    logic [31:0] inst;
    logic        instValid;
    logic [31:0] pc;
    logic        exec_done;
    logic [31:0] dnpc;
    logic        fetch_err;
    logic [1:0]  stateDbg;

    ysyx_23060061_ifu dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (bus),
        .inst      (inst),
        .instValid (instValid),
        .pc        (pc),
        .exec_done (exec_done),
        .dnpc      (dnpc),
        .fetch_err (fetch_err),
        .stateDbg  (stateDbg)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];     // expected inst at each instValid rise
    logic [31:0] pcExp_q[$];   // expected pc at each instValid rise
    logic [31:0] addrExp_q[$]; // expected araddr at each AR handshake

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // scoreboard monitor
    logic prevValid = 1'b0;
    always @(negedge clk) begin
        if (bus.arvalid && bus.arready) begin
            if (addrExp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ar_unexpected: got araddr %h, expected no request", bus.araddr);
            end else begin
                check("ar_addr", bus.araddr, addrExp_q.pop_front());
            end
        end
        if (instValid && !prevValid) begin
            if (exp_q.size() == 0 || pcExp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL inst_unexpected: got inst %h, expected no instruction", inst);
            end else begin
                check("inst_data", inst, exp_q.pop_front());
                check("inst_pc", pc, pcExp_q.pop_front());
            end
        end
        prevValid = instValid;
    end

    // driver tasks: all start and end at posedge+1
    task automatic arPhase(input int stall, input logic [31:0] addr);
        logic got;
        addrExp_q.push_back(addr);
        bus.arready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("ar_stall_valid", 32'(bus.arvalid), 32'd1);
            check("ar_stall_addr", bus.araddr, addr);
            check("ar_stall_rready", 32'(bus.rready), 32'd0);
            @(posedge clk); #1;
        end
        bus.arready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.arvalid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("ar_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.arready = 1'b0;
    endtask

    task automatic rPhase(input int stall, input logic [31:0] data, input logic [1:0] resp,
                          input logic [31:0] expPc);
        bus.rvalid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("r_stall_rready", 32'(bus.rready), 32'd1);
            check("r_stall_arvalid", 32'(bus.arvalid), 32'd0);
            @(posedge clk); #1;
        end
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        if (resp == RESP_OKAY) begin
            exp_q.push_back(data);
            pcExp_q.push_back(expPc);
        end
        @(negedge clk);
        check("r_rready", 32'(bus.rready), 32'd1);
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
        bus.rresp  = RESP_OKAY;
    endtask

    task automatic execPhase(input int delay, input logic [31:0] target,
                             input logic [31:0] expInst, input logic [31:0] expPc);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(instValid), 32'd1);
            check("hold_inst", inst, expInst);
            check("hold_pc", pc, expPc);
            @(posedge clk); #1;
        end
        exec_done = 1'b1;
        dnpc      = target;
        @(negedge clk);
        check("exec_valid", 32'(instValid), 32'd1);
        @(posedge clk); #1;
        exec_done = 1'b0;
        dnpc      = 32'h0;
    endtask

    task automatic resetDut();
        rst = 1'b0;
        #1;
        check("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("rst_rready", 32'(bus.rready), 32'd0);
        check("rst_instValid", 32'(instValid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_state", 32'(stateDbg), 32'(S_REQ));
        check("rst_pc", pc, 32'h8000_0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        bus.rresp   = RESP_OKAY;
        exec_done   = 1'b0;
        dnpc        = 32'h0;
        rst         = 1'b1;
        @(posedge clk); #1;

        // reset, then first request appears on the first edge out of reset
        resetDut();
        @(posedge clk); #1;
        check("t1_arvalid", 32'(bus.arvalid), 32'd1);
        check("t1_araddr", bus.araddr, 32'h8000_0000);
        check("t1_instValid", 32'(instValid), 32'd0);

        // zero-wait fetch
        arPhase(0, 32'h8000_0000);
        rPhase(0, 32'h0010_0073, RESP_OKAY, 32'h8000_0000);
        execPhase(0, 32'h8000_0004, 32'h0010_0073, 32'h8000_0000);
        check("t2_valid_drop", 32'(instValid), 32'd0);
        check("t2_next_arvalid", 32'(bus.arvalid), 32'd1);
        check("t2_next_araddr", bus.araddr, 32'h8000_0004);

        // stalled AR, R and exec_done
        arPhase(4, 32'h8000_0004);
        rPhase(3, 32'h0000_0013, RESP_OKAY, 32'h8000_0004);
        execPhase(5, 32'h8000_0008, 32'h0000_0013, 32'h8000_0004);
        check("t3_next_araddr", bus.araddr, 32'h8000_0008);

        // misaligned target
        arPhase(0, 32'h8000_0008);
        rPhase(0, 32'h0000_006f, RESP_OKAY, 32'h8000_0008);
        execPhase(0, 32'h8000_0102, 32'h0000_006f, 32'h8000_0008);
        check("t5_fetch_err", 32'(fetch_err), 32'd1);
        check("t5_pc_kept", pc, 32'h8000_0008);
        check("t5_state", 32'(stateDbg), 32'(S_ERR));
        bus.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_ar", 32'(bus.arvalid), 32'd0);
            check("t5_no_valid", 32'(instValid), 32'd0);
        end
        @(posedge clk); #1;
        bus.arready = 1'b0;

        // bus error
        resetDut();
        @(posedge clk); #1;
        arPhase(0, 32'h8000_0000);
        rPhase(0, 32'hdead_beef, 2'b10, 32'h8000_0000);
        check("t4_fetch_err", 32'(fetch_err), 32'd1);
        check("t4_state", 32'(stateDbg), 32'(S_ERR));
        bus.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_no_ar", 32'(bus.arvalid), 32'd0);
            check("t4_no_valid", 32'(instValid), 32'd0);
            check("t4_no_rready", 32'(bus.rready), 32'd0);
            check("t4_err_sticky", 32'(fetch_err), 32'd1);
        end
        @(posedge clk); #1;
        bus.arready = 1'b0;

        // asynchronous reset in the middle of S_RESP
        resetDut();
        @(posedge clk); #1;
        arPhase(0, 32'h8000_0000);
        #2;
        check("t6_in_resp", 32'(bus.rready), 32'd1);
        resetDut();
        @(posedge clk); #1;
        check("t6_restart_arvalid", 32'(bus.arvalid), 32'd1);
        check("t6_restart_addr", bus.araddr, 32'h8000_0000);
        arPhase(0, 32'h8000_0000);
        rPhase(0, 32'h0000_0297, RESP_OKAY, 32'h8000_0000);
        execPhase(0, 32'h8000_0004, 32'h0000_0297, 32'h8000_0000);
        check("t6_next_araddr", bus.araddr, 32'h8000_0004);

        @(negedge clk);
        check("queues_drained", 32'(exp_q.size() + pcExp_q.size() + addrExp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
